duck_shooter_logic: RTL and testbench
=====================================

# duck_shooter_logic

Parametrised successor to the single-duck game-logic block: tracks magazine and reserve ammunition, detects hits against up to N_DUCKS simultaneous targets, keeps the score, and sequences start delay, reload and game-over. Sits between the mouse interface (positions, buttons) and the duck controllers and HUD/draw blocks. It adds multi-target hit arbitration, per-duck hit pulses, optional auto-reload, partial reloads from a limited reserve, and an explicit game-over state.

## Interface
- N_DUCKS, 2, number of targets checked per shot (1..8)
- MAG_SIZE, 3, magazine capacity (1..7)
- TOTAL_AMMO, 30, total rounds per game including the first magazine (≥ MAG_SIZE, ≤ 63)
- DUCK_W / DUCK_H, 64 / 64, hitbox size in pixels
- START_DELAY, 260_000, cycles from game_enable to hunt_start
- RELOAD_CYCLES, 260_000, reload duration in cycles
- AUTO_RELOAD, 0, 1 = start reload automatically when magazine empties
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active-low
- game_enable  in  1  level; low forces IDLE
- left_mouse / right_mouse  in  1  raw button levels (shoot / reload)
- mouse_xpos / mouse_ypos  in  12  cursor position
- duck_xpos / duck_ypos  in  12*N_DUCKS  packed top-left corners, duck i at [12*i +: 12]
- duck_alive  in  N_DUCKS  target i is hittable
- bullets_in_magazine  out  3  rounds in magazine
- bullets_left  out  6  reserve rounds
- my_score  out  7  hit count, saturates at 127
- hunt_start  out  1  level, high in READY and RELOADING
- show_reload_char  out  1  reload prompt
- duck_hit  out  N_DUCKS  one-cycle hit pulse per duck
- game_over  out  1  level, high in GAME_OVER

## Operation
- States: IDLE, START_WAIT, READY, RELOADING, GAME_OVER.
- IDLE: counters held at initial values (mag=MAG_SIZE, left=TOTAL_AMMO−MAG_SIZE, score=0). game_enable=1 → START_WAIT, delay counter cleared.
- START_WAIT: count to START_DELAY−1, then → READY.
- Button edges: registered previous levels; shot = left_mouse & ~left_prev, reload_req = right_mouse & ~right_prev. Edge registers update in every state, so a button held across a state change does not fire.
- READY, shot, mag>0: mag−1. Hit test per duck i: duck_alive[i] and duck_x ≤ mouse_x < duck_x+DUCK_W and duck_y ≤ mouse_y < duck_y+DUCK_H, sums computed 13 bits wide (no wrap). Lowest hit index wins: duck_hit[i] pulses, score+1 (saturating). At most one duck per shot. Miss: only mag decrements.
- READY, shot, mag=0: ignored.
- READY, reload_req, mag<MAG_SIZE and left>0 (or AUTO_RELOAD and mag reaches 0 with left>0): → RELOADING. Shot and reload_req in the same cycle: shot wins, reload_req dropped.
- RELOADING: all shot/reload edges ignored; after RELOAD_CYCLES cycles transfer k=min(MAG_SIZE−mag, left): mag+k, left−k, → READY.
- mag=0 and left=0 while READY → GAME_OVER (evaluated after the shot's update).
- GAME_OVER: outputs frozen, game_over=1; exits only via game_enable=0.
- game_enable=0 in any state → IDLE next cycle, counters reinitialised, in-progress reload abandoned.
- show_reload_char = 1 when in READY with mag=0 and left>0, or in RELOADING.

## Timing
- Reset (rst_n=0 at a clk edge): state IDLE, bullets_in_magazine=MAG_SIZE, bullets_left=TOTAL_AMMO−MAG_SIZE, my_score=0, duck_hit=0, hunt_start=0, show_reload_char=0, game_over=0, edge registers=0. Reset mid-reload or mid-game behaves identically.
- Shot latency: button high in cycle t (low in t−1) → counters, score and duck_hit visible in t+1. duck_hit is high for exactly that one cycle.
- hunt_start rises START_DELAY cycles after the first cycle with game_enable=1 in IDLE.
- Reload: entered at t+1; counters updated RELOAD_CYCLES cycles later, in the same cycle the state returns to READY.
- GAME_OVER entered the cycle after the final count update.
- All outputs are registered.

## Test plan
- Reset, then game_enable=1, START_DELAY=100 → hunt_start rises exactly 100 cycles later; mag=3, left=27, score=0.
- Cursor (1200,800), ducks at (100,100)/(300,100), one left click → mag=2, score=0, duck_hit=00. Cursor (102,102) → mag=1, score=1, duck_hit=01 for one cycle. Held button for 50 cycles → only one shot.
- Both ducks at (100,100), shot at (110,110) → duck_hit=01 only. Same with duck_alive=10 → duck_hit=10. Shot at (164,100) → miss (boundary exclusive).
- Empty magazine, left click → no change, show_reload_char=1. Right click → RELOADING, clicks ignored; after RELOAD_CYCLES mag=3, left reduced by 3. With AUTO_RELOAD=1, reload starts without right click.
- TOTAL_AMMO=5, MAG_SIZE=3: fire 3, reload → mag=2, left=0. Fire 2 → game_over=1 next cycle, clicks ignored; game_enable=0 → IDLE, mag=3, left=2.
- Assert rst_n=0 or game_enable=0 mid-reload → all outputs return to initial values next cycle. 127 hits → score stays 127.

Source files
------------

// File: rtl/duck_shooter_logic.sv
// Duck-hunt game logic: ammo, multi-target hit arbitration, score and game sequencing.
// Shot results appear one cycle after the button edge; all outputs are registered.
module duck_shooter_logic #(
  parameter int N_DUCKS       = 2,
  parameter int MAG_SIZE      = 3,
  parameter int TOTAL_AMMO    = 30,
  parameter int DUCK_W        = 64,
  parameter int DUCK_H        = 64,
  parameter int START_DELAY   = 260_000,
  parameter int RELOAD_CYCLES = 260_000,
  parameter int AUTO_RELOAD   = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   game_enable,
  input  logic                   left_mouse,
  input  logic                   right_mouse,
  input  logic [11:0]            mouse_xpos,
  input  logic [11:0]            mouse_ypos,
  input  logic [12*N_DUCKS-1:0]  duck_xpos,
  input  logic [12*N_DUCKS-1:0]  duck_ypos,
  input  logic [N_DUCKS-1:0]     duck_alive,
  output logic [2:0]             bullets_in_magazine,
  output logic [5:0]             bullets_left,
  output logic [6:0]             my_score,
  output logic                   hunt_start,
  output logic                   show_reload_char,
  output logic [N_DUCKS-1:0]     duck_hit,
  output logic                   game_over
);

  typedef enum logic [2:0] {IDLE, START_WAIT, READY, RELOADING, GAME_OVER} state_t;

  localparam logic [2:0]  MAG_FULL    = 3'(MAG_SIZE);
  localparam logic [5:0]  RESERVE0    = 6'(TOTAL_AMMO - MAG_SIZE);
  localparam logic [31:0] START_LAST  = 32'(START_DELAY - 1);
  localparam logic [31:0] RELOAD_LAST = 32'(RELOAD_CYCLES - 1);
  localparam logic [12:0] W13         = 13'(DUCK_W);
  localparam logic [12:0] H13         = 13'(DUCK_H);

  state_t              state;
  logic [31:0]         cnt;
  logic                left_prev, right_prev;
  logic                shot, reload_req, fire, want_reload;
  logic [N_DUCKS-1:0]  hit_cand, hit_first;
  logic [2:0]          mag_next;
  logic [6:0]          score_next;
  logic [5:0]          space, refill;

  always_comb begin
    shot       = left_mouse & ~left_prev;
    reload_req = right_mouse & ~right_prev;
    hit_cand   = '0;
    // Bounds are compared 13 bits wide so a duck near the screen edge never wraps.
    for (int i = 0; i < N_DUCKS; i++) begin
      hit_cand[i] = duck_alive[i]
        && ({1'b0, duck_xpos[12*i +: 12]} <= {1'b0, mouse_xpos})
        && ({1'b0, mouse_xpos} < {1'b0, duck_xpos[12*i +: 12]} + W13)
        && ({1'b0, duck_ypos[12*i +: 12]} <= {1'b0, mouse_ypos})
        && ({1'b0, mouse_ypos} < {1'b0, duck_ypos[12*i +: 12]} + H13);
    end
    hit_first   = hit_cand & (~hit_cand + N_DUCKS'(1));
    fire        = shot && (bullets_in_magazine != 3'd0);
    mag_next    = fire ? bullets_in_magazine - 3'd1 : bullets_in_magazine;
    score_next  = (fire && (|hit_cand) && (my_score != 7'd127)) ? my_score + 7'd1 : my_score;
    want_reload = (bullets_left != 6'd0) &&
                  ((!shot && reload_req && (bullets_in_magazine < MAG_FULL)) ||
                   ((AUTO_RELOAD != 0) && (mag_next == 3'd0)));
    space       = {3'b000, MAG_FULL - bullets_in_magazine};
    refill      = (space < bullets_left) ? space : bullets_left;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state               <= IDLE;
      cnt                 <= '0;
      left_prev           <= 1'b0;
      right_prev          <= 1'b0;
      bullets_in_magazine <= MAG_FULL;
      bullets_left        <= RESERVE0;
      my_score            <= '0;
      duck_hit            <= '0;
      hunt_start          <= 1'b0;
      show_reload_char    <= 1'b0;
      game_over           <= 1'b0;
    end else begin
      left_prev  <= left_mouse;
      right_prev <= right_mouse;
      duck_hit   <= '0;
      if (!game_enable) begin
        state               <= IDLE;
        cnt                 <= '0;
        bullets_in_magazine <= MAG_FULL;
        bullets_left        <= RESERVE0;
        my_score            <= '0;
        hunt_start          <= 1'b0;
        show_reload_char    <= 1'b0;
        game_over           <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            // The enabling cycle is the first cycle of the start delay.
            cnt <= 32'd1;
            if (START_DELAY <= 1) begin
              state      <= READY;
              hunt_start <= 1'b1;
            end else begin
              state <= START_WAIT;
            end
          end
          START_WAIT: begin
            if (cnt >= START_LAST) begin
              state      <= READY;
              hunt_start <= 1'b1;
            end else begin
              cnt <= cnt + 32'd1;
            end
          end
          READY: begin
            if (bullets_in_magazine == 3'd0 && bullets_left == 6'd0) begin
              state            <= GAME_OVER;
              hunt_start       <= 1'b0;
              show_reload_char <= 1'b0;
              game_over        <= 1'b1;
            end else begin
              bullets_in_magazine <= mag_next;
              my_score            <= score_next;
              duck_hit            <= fire ? hit_first : '0;
              if (want_reload) begin
                state            <= RELOADING;
                cnt              <= '0;
                show_reload_char <= 1'b1;
              end else begin
                show_reload_char <= (mag_next == 3'd0) && (bullets_left != 6'd0);
              end
            end
          end
          RELOADING: begin
            if (cnt >= RELOAD_LAST) begin
              state               <= READY;
              bullets_in_magazine <= bullets_in_magazine + refill[2:0];
              bullets_left        <= bullets_left - refill;
              show_reload_char    <= 1'b0;
            end else begin
              cnt <= cnt + 32'd1;
            end
          end
          GAME_OVER: begin
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_duck_shooter_logic.sv
// Bench for duck_shooter_logic: directed sequences, a hit-test vector table and a random run vs. a model.
module tb_duck_shooter_logic;

  localparam int SD  = 100;
  localparam int SD2 = 10;
  localparam int RC  = 20;
  localparam int MAG = 3;
  localparam int TOT = 30;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, ge_m, ge_s, ge_a, lm, rm;
  logic [11:0] mx, my;
  logic [23:0] dx, dy;
  logic [1:0]  alive;

  logic [2:0] m_mag, s_mag, a_mag;
  logic [5:0] m_left, s_left, a_left;
  logic [6:0] m_score, s_score, a_score;
  logic       m_hunt, s_hunt, a_hunt, m_show, s_show, a_show, m_go, s_go, a_go;
  logic [1:0] m_hit, s_hit, a_hit;

  duck_shooter_logic #(.N_DUCKS(2), .MAG_SIZE(MAG), .TOTAL_AMMO(TOT), .START_DELAY(SD),
                       .RELOAD_CYCLES(RC), .AUTO_RELOAD(0)) u_main (
    .clk(clk), .rst_n(rst_n), .game_enable(ge_m), .left_mouse(lm), .right_mouse(rm),
    .mouse_xpos(mx), .mouse_ypos(my), .duck_xpos(dx), .duck_ypos(dy), .duck_alive(alive),
    .bullets_in_magazine(m_mag), .bullets_left(m_left), .my_score(m_score),
    .hunt_start(m_hunt), .show_reload_char(m_show), .duck_hit(m_hit), .game_over(m_go));

  duck_shooter_logic #(.N_DUCKS(2), .MAG_SIZE(MAG), .TOTAL_AMMO(5), .START_DELAY(SD2),
                       .RELOAD_CYCLES(RC), .AUTO_RELOAD(0)) u_small (
    .clk(clk), .rst_n(rst_n), .game_enable(ge_s), .left_mouse(lm), .right_mouse(rm),
    .mouse_xpos(mx), .mouse_ypos(my), .duck_xpos(dx), .duck_ypos(dy), .duck_alive(alive),
    .bullets_in_magazine(s_mag), .bullets_left(s_left), .my_score(s_score),
    .hunt_start(s_hunt), .show_reload_char(s_show), .duck_hit(s_hit), .game_over(s_go));

  duck_shooter_logic #(.N_DUCKS(2), .MAG_SIZE(MAG), .TOTAL_AMMO(TOT), .START_DELAY(SD2),
                       .RELOAD_CYCLES(RC), .AUTO_RELOAD(1)) u_auto (
    .clk(clk), .rst_n(rst_n), .game_enable(ge_a), .left_mouse(lm), .right_mouse(rm),
    .mouse_xpos(mx), .mouse_ypos(my), .duck_xpos(dx), .duck_ypos(dy), .duck_alive(alive),
    .bullets_in_magazine(a_mag), .bullets_left(a_left), .my_score(a_score),
    .hunt_start(a_hunt), .show_reload_char(a_show), .duck_hit(a_hit), .game_over(a_go));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic click_l();
    lm = 1'b1;
    tick();
    lm = 1'b0;
  endtask

  task automatic place(input int x0, input int y0, input int x1, input int y1);
    dx = {12'(x1), 12'(x0)};
    dy = {12'(y1), 12'(y0)};
  endtask

  task automatic restart_main();
    ge_m = 1'b0;
    tick();
    ge_m = 1'b1;
    repeat (SD) tick();
  endtask

  // Reference model: phases with edge timestamps instead of counters.
  localparam int P_IDLE = 0, P_START = 1, P_READY = 2, P_RELOAD = 3, P_OVER = 4;
  int   ph, em, el, es, mark, n;
  logic lp, rp;
  logic [1:0] e_hit;

  function automatic bit inside_duck(input int i);
    int x, y;
    x = int'(dx[12*i +: 12]);
    y = int'(dy[12*i +: 12]);
    return alive[i] && int'(mx) >= x && int'(mx) < x + 64 && int'(my) >= y && int'(my) < y + 64;
  endfunction

  task automatic model_step();
    bit sh, rr;
    int k;
    e_hit = 2'b00;
    sh = lm && !lp;
    rr = rm && !rp;
    lp = lm;
    rp = rm;
    if (!ge_m) begin
      ph = P_IDLE; em = MAG; el = TOT - MAG; es = 0;
    end else begin
      case (ph)
        P_IDLE:  begin ph = P_START; mark = n; end
        P_START: if (n - mark == SD - 1) ph = P_READY;
        P_READY: begin
          if (em == 0 && el == 0) ph = P_OVER;
          else if (sh && em > 0) begin
            em--;
            for (int i = 0; i < 2; i++) begin
              if (e_hit == 2'b00 && inside_duck(i)) begin
                e_hit[i] = 1'b1;
                es = (es < 127) ? es + 1 : 127;
              end
            end
          end else if (!sh && rr && em < MAG && el > 0) begin
            ph = P_RELOAD; mark = n;
          end
        end
        P_RELOAD: if (n - mark == RC) begin
          k  = (MAG - em < el) ? MAG - em : el;
          em = em + k; el = el - k; ph = P_READY;
        end
        default: ;
      endcase
    end
    n++;
  endtask

  typedef struct {
    int mx, my, x0, y0, x1, y1;
    logic [1:0] alv;
    logic [1:0] hit;
  } vec_t;

  vec_t vt[10];

  initial begin
    vt[0] = '{1200, 800, 100, 100, 300, 100, 2'b11, 2'b00};
    vt[1] = '{102, 102, 100, 100, 300, 100, 2'b11, 2'b01};
    vt[2] = '{310, 150, 100, 100, 300, 100, 2'b11, 2'b10};
    vt[3] = '{110, 110, 100, 100, 100, 100, 2'b11, 2'b01};
    vt[4] = '{110, 110, 100, 100, 100, 100, 2'b10, 2'b10};
    vt[5] = '{164, 100, 100, 100, 100, 100, 2'b11, 2'b00};
    vt[6] = '{163, 163, 100, 100, 100, 100, 2'b11, 2'b01};
    vt[7] = '{100, 164, 100, 100, 100, 100, 2'b11, 2'b00};
    vt[8] = '{4090, 4090, 4080, 4080, 300, 100, 2'b11, 2'b01};
    vt[9] = '{102, 102, 100, 100, 100, 100, 2'b00, 2'b00};

    rst_n = 1'b0; ge_m = 1'b0; ge_s = 1'b0; ge_a = 1'b0; lm = 1'b0; rm = 1'b0;
    mx = 12'd1200; my = 12'd800; alive = 2'b11;
    place(100, 100, 300, 100);
    tick(); tick();
    chk("reset_outs", {m_mag, m_left, m_score, m_hit, m_hunt, m_show, m_go},
        {3'd3, 6'd27, 7'd0, 2'b00, 1'b0, 1'b0, 1'b0});
    rst_n = 1'b1;
    tick();

    ge_m = 1'b1;
    repeat (SD - 1) tick();
    chk("hunt_before_delay", m_hunt, 0);
    tick();
    chk("hunt_at_delay", {m_hunt, m_mag, m_left, m_score}, {1'b1, 3'd3, 6'd27, 7'd0});

    click_l();
    chk("miss_shot", {m_mag, m_score, m_hit}, {3'd2, 7'd0, 2'b00});
    tick();
    mx = 12'd102; my = 12'd102;
    click_l();
    chk("hit_shot", {m_mag, m_score, m_hit}, {3'd1, 7'd1, 2'b01});
    tick();
    chk("hit_pulse_one_cycle", m_hit, 2'b00);

    lm = 1'b1;
    repeat (50) tick();
    lm = 1'b0;
    tick();
    chk("held_button_one_shot", {m_mag, m_score, m_show}, {3'd0, 7'd2, 1'b1});
    click_l();
    chk("empty_click", {m_mag, m_score, m_show, m_hit}, {3'd0, 7'd2, 1'b1, 2'b00});
    tick();

    rm = 1'b1;
    tick();
    rm = 1'b0;
    chk("reload_entered", {m_hunt, m_show}, {1'b1, 1'b1});
    click_l();
    tick();
    repeat (RC - 3) tick();
    chk("reload_not_done", {m_mag, m_score}, {3'd0, 7'd2});
    tick();
    chk("reload_done", {m_mag, m_left, m_show, m_hunt}, {3'd3, 6'd24, 1'b0, 1'b1});

    click_l(); tick();
    rm = 1'b1; tick(); rm = 1'b0;
    repeat (5) tick();
    ge_m = 1'b0;
    tick();
    chk("disable_mid_reload", {m_mag, m_left, m_score, m_hit, m_hunt, m_show, m_go},
        {3'd3, 6'd27, 7'd0, 2'b00, 1'b0, 1'b0, 1'b0});

    ge_m = 1'b1;
    repeat (SD) tick();
    click_l(); tick();
    rm = 1'b1; tick(); rm = 1'b0;
    repeat (5) tick();
    ge_m = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("reset_mid_reload", {m_mag, m_left, m_score, m_hit, m_hunt, m_show, m_go},
        {3'd3, 6'd27, 7'd0, 2'b00, 1'b0, 1'b0, 1'b0});

    foreach (vt[v]) begin
      restart_main();
      mx = 12'(vt[v].mx); my = 12'(vt[v].my); alive = vt[v].alv;
      place(vt[v].x0, vt[v].y0, vt[v].x1, vt[v].y1);
      click_l();
      chk($sformatf("vec%0d_hit", v), {m_hit, m_mag, m_score},
          {vt[v].hit, 3'd2, 7'((vt[v].hit != 2'b00) ? 1 : 0)});
      tick();
      chk($sformatf("vec%0d_pulse_end", v), m_hit, 2'b00);
    end
    ge_m = 1'b0;
    alive = 2'b11;
    mx = 12'd1200; my = 12'd800;
    place(100, 100, 300, 100);

    ge_s = 1'b1;
    repeat (SD2) tick();
    chk("small_ready", {s_hunt, s_mag, s_left}, {1'b1, 3'd3, 6'd2});
    repeat (3) begin click_l(); tick(); end
    chk("small_empty", {s_mag, s_left, s_show}, {3'd0, 6'd2, 1'b1});
    rm = 1'b1; tick(); rm = 1'b0;
    repeat (RC - 1) tick();
    chk("small_reload_wait", s_mag, 3'd0);
    tick();
    chk("small_partial_reload", {s_mag, s_left}, {3'd2, 6'd0});
    click_l(); tick();
    click_l();
    chk("small_last_shot", {s_mag, s_left, s_go, s_show}, {3'd0, 6'd0, 1'b0, 1'b0});
    tick();
    chk("small_game_over", {s_go, s_hunt, s_show}, {1'b1, 1'b0, 1'b0});
    click_l(); tick();
    rm = 1'b1; tick(); rm = 1'b0;
    chk("small_over_frozen", {s_go, s_mag, s_left}, {1'b1, 3'd0, 6'd0});
    ge_s = 1'b0;
    tick();
    chk("small_back_idle", {s_go, s_mag, s_left, s_hunt}, {1'b0, 3'd3, 6'd2, 1'b0});

    ge_a = 1'b1;
    repeat (SD2) tick();
    click_l(); tick();
    click_l(); tick();
    click_l();
    chk("auto_reload_entered", {a_mag, a_show, a_hunt}, {3'd0, 1'b1, 1'b1});
    repeat (RC - 1) tick();
    chk("auto_reload_wait", a_mag, 3'd0);
    tick();
    chk("auto_reload_done", {a_mag, a_left, a_show}, {3'd3, 6'd24, 1'b0});
    ge_a = 1'b0;

    ge_m = 1'b0; lm = 1'b0; rm = 1'b0;
    tick(); tick();
    ph = P_IDLE; em = MAG; el = TOT - MAG; es = 0; mark = 0; n = 0; lp = 1'b0; rp = 1'b0;
    e_hit = 2'b00;
    for (int i = 0; i < 6000; i++) begin
      if (i % 64 == 0) begin
        dx = {12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095))};
        dy = {12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095))};
      end
      if (i % 16 == 0) alive = 2'($urandom);
      if (i % 4 == 0) begin
        int j;
        j  = int'($urandom_range(0, 1));
        mx = dx[12*j +: 12] + 12'($urandom_range(0, 80)) - 12'd8;
        my = dy[12*j +: 12] + 12'($urandom_range(0, 80)) - 12'd8;
      end
      lm   = ($urandom_range(0, 3) == 0);
      rm   = ($urandom_range(0, 15) == 0);
      ge_m = ($urandom_range(0, 499) != 0);
      @(posedge clk);
      model_step();
      #1;
      chk("random_cycle", {m_mag, m_left, m_score, m_hit, m_hunt, m_show, m_go},
          {3'(em), 6'(el), 7'(es), e_hit,
           1'(ph == P_READY || ph == P_RELOAD),
           1'((ph == P_READY && em == 0 && el > 0) || ph == P_RELOAD),
           1'(ph == P_OVER)});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
